md_issue_ctrl: RTL and testbench

- Initiator side of the EX-stage multicycle divide handshake.
- Accepts DIV/DIVU from the EX stage, latches the operands, and drives the divider's request/operand inputs.
- Holds the request until the divider signals completion, then writes remainder to HI and quotient to LO.
- Stalls EX while busy, services MTHI/MTLO, and aborts cleanly on pipeline flush.

---
 rtl/md_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_md_issue_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: EX-stage initiator for the multicycle divider.
// Latches DIV/DIVU operands and holds div_req until the divider completes.
// It then writes the remainder to HI and the quotient to LO.
// It stalls EX while busy, services MTHI/MTLO and aborts on flush.
//
// Handshake: div_req is a registered level. It rises the cycle after
// issue and stays high, with div_x/div_y/div_signed frozen, until
// div_complete (writeback) or ex_flush (abort) is seen. After that it
// stays low for GAP_CYCLES cycles so the divider can re-arm.
// div_complete is only honoured while in BUSY.
module md_issue_ctrl #(
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_div,
  input  logic        ex_divu,
  input  logic        ex_mthi,
  input  logic        ex_mtlo,
  input  logic        ex_flush,
  input  logic [31:0] ex_src_a,
  input  logic [31:0] ex_src_b,
  output logic        ex_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_req,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_complete,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] gap_cnt;
  logic       gap_last;
  logic       op_valid;
  logic       issue;
  logic       writeback;
  logic       mt_ok;

  assign state    = state_q;
  assign op_valid = (ex_div | ex_divu) & ~ex_flush;
  assign gap_last = (gap_cnt == 2'(GAP_CYCLES - 1));
  // MT writes are accepted whenever no divide is in flight.
  assign mt_ok    = (state_q != BUSY) & ~ex_flush;

  // Next-state, issue/writeback strobes and the EX stall.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    writeback = 1'b0;
    ex_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          issue    = 1'b1;
          ex_stall = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        ex_stall = ~div_complete & ~ex_flush;
        if (ex_flush) begin
          state_d = GAP;
        end else if (div_complete) begin
          writeback = 1'b1;
          state_d   = GAP;
        end
      end
      GAP: begin
        // A waiting divide stays stalled through the gap. On the last gap
        // cycle it is issued, so that div_req is low for exactly
        // GAP_CYCLES cycles between back-to-back operations.
        ex_stall = op_valid;
        if (gap_last) begin
          if (op_valid) begin
            issue   = 1'b1;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      ex_stall = 1'b0;
    end
  end

  // State register, gap counter, divider request/operands and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gap_cnt    <= 2'd0;
      div_req    <= 1'b0;
      div_signed <= 1'b0;
      div_x      <= 32'd0;
      div_y      <= 32'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == GAP && !gap_last) begin
        gap_cnt <= gap_cnt + 2'd1;
      end else begin
        gap_cnt <= 2'd0;
      end
      if (issue) begin
        div_req    <= 1'b1;
        div_signed <= ex_div;
        div_x      <= ex_src_a;
        div_y      <= ex_src_b;
      end else if (state_q == BUSY && state_d != BUSY) begin
        div_req <= 1'b0;
      end
      if (writeback) begin
        hi <= div_r;
        lo <= div_s;
      end else begin
        if (mt_ok && ex_mthi) hi <= ex_src_a;
        if (mt_ok && ex_mtlo) lo <= ex_src_a;
      end
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Testbench for md_issue_ctrl: a behavioural 34-cycle divider plus
// scenario tasks. Expected HI/LO values are queued when an operation is
// driven and popped when its writeback is observed.
module tb_md_issue_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_div = 1'b0;
  logic        ex_divu = 1'b0;
  logic        ex_mthi = 1'b0;
  logic        ex_mtlo = 1'b0;
  logic        ex_flush = 1'b0;
  logic [31:0] ex_src_a = '0;
  logic [31:0] ex_src_b = '0;
  logic        ex_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_req;
  logic        div_signed;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic [31:0] div_s;
  logic [31:0] div_r;
  logic        div_complete;
  logic [1:0]  state;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e_lo;
  logic [31:0] e_hi;

  md_issue_ctrl #(.GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .ex_div(ex_div), .ex_divu(ex_divu), .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo),
    .ex_flush(ex_flush), .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
    .ex_stall(ex_stall), .hi(hi), .lo(lo),
    .div_req(div_req), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
    .div_s(div_s), .div_r(div_r), .div_complete(div_complete), .state(state)
  );

  // Clock
  always #5 clk = ~clk;

  // Divider model: complete 34 cycles after div_req is first seen high.
  int   dcnt = 0;
  logic done = 1'b0;
  always @(posedge clk) begin
    if (reset || !div_req) begin
      dcnt <= 0;
      done <= 1'b0;
    end else if (dcnt == 33) begin
      done <= 1'b1;
    end else begin
      dcnt <= dcnt + 1;
    end
  end
  assign div_complete = done & div_req;

  always_comb begin
    div_s = 32'hFFFFFFFF;
    div_r = div_x;
    if (div_y != 32'd0) begin
      if (div_signed) begin
        div_s = 32'($signed(div_x) / $signed(div_y));
        div_r = 32'($signed(div_x) % $signed(div_y));
      end else begin
        div_s = div_x / div_y;
        div_r = div_x % div_y;
      end
    end
  end

  // Driver: present a divide in EX (inputs change on the falling edge).
  task automatic drive_div(input bit is_signed, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ex_div   = is_signed;
    ex_divu  = ~is_signed;
    ex_src_a = a;
    ex_src_b = b;
    #1;
  endtask

  // Driver: wait (bounded) for div_complete, watching stall and div_signed.
  task automatic wait_complete(input bit exp_signed, output bit ok, output bit stall_bad,
                               output bit sign_bad);
    ok = 1'b0;
    stall_bad = 1'b0;
    sign_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (div_complete) begin
        ok = 1'b1;
        break;
      end
      if (ex_stall !== 1'b1) stall_bad = 1'b1;
      if (div_signed !== exp_signed || div_req !== 1'b1) sign_bad = 1'b1;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ex_div = 1'b1;
    ex_src_a = 32'h1234;
    ex_src_b = 32'h5;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (ex_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", ex_stall);
    else n_pass++;
    ex_div = 1'b0;
    @(negedge clk);
    n_total++;
    if ({div_req, div_signed, div_x, div_y, hi, lo, state} !== {2'b00, 128'd0, S_IDLE})
      $display("FAIL reset_state got req=%b sgn=%b x=%h y=%h hi=%h lo=%h st=%0d exp all zero",
               div_req, div_signed, div_x, div_y, hi, lo, state);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_div_signed();
    bit ok, sb, gb;
    drive_div(1'b1, 32'hFFFFFFF9, 32'd2);
    exp_q.push_back(32'hFFFFFFFD);
    exp_q.push_back(32'hFFFFFFFF);
    n_total++;
    if (ex_stall !== 1'b1) $display("FAIL div_issue_stall got %b exp 1", ex_stall);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({div_req, div_signed, div_x, div_y} !== {2'b11, 32'hFFFFFFF9, 32'd2})
      $display("FAIL div_launch got req=%b sgn=%b x=%h y=%h exp 1 1 fffffff9 00000002",
               div_req, div_signed, div_x, div_y);
    else n_pass++;
    wait_complete(1'b1, ok, sb, gb);
    n_total++;
    if ({ok, sb, gb, ex_stall} !== 4'b1000)
      $display("FAIL div_busy got done=%b stall_drop=%b req_bad=%b stall_at_done=%b exp 1 0 0 0",
               ok, sb, gb, ex_stall);
    else n_pass++;
    @(negedge clk);
    ex_div = 1'b0;
    e_lo = exp_q.pop_front();
    e_hi = exp_q.pop_front();
    n_total++;
    if ({lo, hi, div_req} !== {e_lo, e_hi, 1'b0})
      $display("FAIL div_result got lo=%h hi=%h req=%b exp lo=%h hi=%h req=0", lo, hi, div_req, e_lo, e_hi);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_divu_and_mt_gap();
    bit ok, sb, gb;
    drive_div(1'b0, 32'hFFFFFFF9, 32'd2);
    exp_q.push_back(32'h7FFFFFFC);
    exp_q.push_back(32'h00000001);
    @(negedge clk);
    #1;
    wait_complete(1'b0, ok, sb, gb);
    n_total++;
    if ({ok, sb, gb, ex_stall} !== 4'b1000)
      $display("FAIL divu_busy got done=%b stall_drop=%b req_or_sign_bad=%b stall_at_done=%b exp 1 0 0 0",
               ok, sb, gb, ex_stall);
    else n_pass++;
    @(negedge clk);
    ex_divu = 1'b0;
    e_lo = exp_q.pop_front();
    e_hi = exp_q.pop_front();
    n_total++;
    if ({lo, hi, div_signed} !== {e_lo, e_hi, 1'b0})
      $display("FAIL divu_result got lo=%h hi=%h sgn=%b exp lo=%h hi=%h sgn=0", lo, hi, div_signed, e_lo, e_hi);
    else n_pass++;
    // MTLO in the gap cycle is serviced without stalling.
    ex_mtlo = 1'b1;
    ex_src_a = 32'h00000055;
    #1;
    n_total++;
    if ({ex_stall, state} !== {1'b0, S_GAP})
      $display("FAIL mt_gap_stall got stall=%b st=%0d exp 0 2", ex_stall, state);
    else n_pass++;
    @(negedge clk);
    ex_mtlo = 1'b0;
    n_total++;
    if ({lo, hi} !== {32'h00000055, 32'h00000001})
      $display("FAIL mt_gap_write got lo=%h hi=%h exp lo=00000055 hi=00000001", lo, hi);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok, sb, gb;
    drive_div(1'b1, 32'd100, 32'd7);
    exp_q.push_back(32'd14);
    exp_q.push_back(32'd2);
    @(negedge clk);
    #1;
    wait_complete(1'b1, ok, sb, gb);
    @(negedge clk);
    // Second op arrives while the controller is in GAP.
    ex_div = 1'b0;
    ex_divu = 1'b1;
    ex_src_a = 32'd50;
    ex_src_b = 32'd5;
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd0);
    #1;
    e_lo = exp_q.pop_front();
    e_hi = exp_q.pop_front();
    n_total++;
    if ({ok, lo, hi, div_req, ex_stall, state} !== {1'b1, e_lo, e_hi, 1'b0, 1'b1, S_GAP})
      $display("FAIL b2b_first got done=%b lo=%h hi=%h req=%b stall=%b st=%0d exp 1 %h %h 0 1 2",
               ok, lo, hi, div_req, ex_stall, state, e_lo, e_hi);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({div_req, div_signed, div_x, div_y} !== {2'b10, 32'd50, 32'd5})
      $display("FAIL b2b_gap_len got req=%b sgn=%b x=%h y=%h exp 1 0 00000032 00000005",
               div_req, div_signed, div_x, div_y);
    else n_pass++;
    wait_complete(1'b0, ok, sb, gb);
    @(negedge clk);
    ex_divu = 1'b0;
    e_lo = exp_q.pop_front();
    e_hi = exp_q.pop_front();
    n_total++;
    if ({ok, sb, gb, lo, hi} !== {3'b100, e_lo, e_hi})
      $display("FAIL b2b_second got done=%b stall_drop=%b req_bad=%b lo=%h hi=%h exp 1 0 0 %h %h",
               ok, sb, gb, lo, hi, e_lo, e_hi);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_flush_busy();
    @(negedge clk);
    ex_mthi = 1'b1;
    ex_src_a = 32'hAAAA0000;
    #1;
    n_total++;
    if (ex_stall !== 1'b0) $display("FAIL mthi_stall got %b exp 0", ex_stall);
    else n_pass++;
    @(negedge clk);
    ex_mthi = 1'b0;
    ex_mtlo = 1'b1;
    ex_src_a = 32'h0000BBBB;
    @(negedge clk);
    ex_mtlo = 1'b0;
    n_total++;
    if ({hi, lo} !== {32'hAAAA0000, 32'h0000BBBB})
      $display("FAIL mt_setup got hi=%h lo=%h exp aaaa0000 0000bbbb", hi, lo);
    else n_pass++;
    drive_div(1'b1, 32'd100, 32'd7);
    @(negedge clk);
    repeat (9) @(negedge clk);
    ex_flush = 1'b1;
    #1;
    n_total++;
    if ({ex_stall, div_req} !== 2'b01)
      $display("FAIL flush_stall got stall=%b req=%b exp stall=0 req=1", ex_stall, div_req);
    else n_pass++;
    @(negedge clk);
    ex_flush = 1'b0;
    ex_div = 1'b0;
    n_total++;
    if ({div_req, hi, lo, state} !== {1'b0, 32'hAAAA0000, 32'h0000BBBB, S_GAP})
      $display("FAIL flush_abort got req=%b hi=%h lo=%h st=%0d exp 0 aaaa0000 0000bbbb 2",
               div_req, hi, lo, state);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (state !== S_IDLE) $display("FAIL flush_idle got st=%0d exp 0", state);
    else n_pass++;
  endtask

  task automatic test_flush_complete();
    bit ok, sb, gb;
    drive_div(1'b1, 32'd9, 32'd3);
    @(negedge clk);
    #1;
    wait_complete(1'b1, ok, sb, gb);
    ex_flush = 1'b1;
    #1;
    n_total++;
    if ({ok, ex_stall} !== 2'b10)
      $display("FAIL flushc_stall got done=%b stall=%b exp 1 0", ok, ex_stall);
    else n_pass++;
    @(negedge clk);
    ex_flush = 1'b0;
    ex_div = 1'b0;
    n_total++;
    if ({div_req, hi, lo} !== {1'b0, 32'hAAAA0000, 32'h0000BBBB})
      $display("FAIL flushc_nowrite got req=%b hi=%h lo=%h exp 0 aaaa0000 0000bbbb", div_req, hi, lo);
    else n_pass++;
    repeat (2) @(negedge clk);
    ex_mthi = 1'b1;
    ex_src_a = 32'h12345678;
    #1;
    n_total++;
    if ({ex_stall, state} !== {1'b0, S_IDLE})
      $display("FAIL mthi_idle_stall got stall=%b st=%0d exp 0 0", ex_stall, state);
    else n_pass++;
    @(negedge clk);
    ex_mthi = 1'b0;
    n_total++;
    if ({hi, lo} !== {32'h12345678, 32'h0000BBBB})
      $display("FAIL mthi_write got hi=%h lo=%h exp 12345678 0000bbbb", hi, lo);
    else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    bit ok, sb, gb;
    drive_div(1'b1, 32'd100, 32'd7);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    ex_div = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_total++;
    if ({div_req, hi, lo, state} !== {1'b0, 64'd0, S_IDLE})
      $display("FAIL rst_busy got req=%b hi=%h lo=%h st=%0d exp 0 0 0 0", div_req, hi, lo, state);
    else n_pass++;
    drive_div(1'b1, 32'd9, 32'd3);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd0);
    @(negedge clk);
    #1;
    wait_complete(1'b1, ok, sb, gb);
    @(negedge clk);
    ex_div = 1'b0;
    e_lo = exp_q.pop_front();
    e_hi = exp_q.pop_front();
    n_total++;
    if ({ok, sb, gb, lo, hi} !== {3'b100, e_lo, e_hi})
      $display("FAIL rst_then_div got done=%b stall_drop=%b req_bad=%b lo=%h hi=%h exp 1 0 0 %h %h",
               ok, sb, gb, lo, hi, e_lo, e_hi);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_div_signed();
    test_divu_and_mt_gap();
    test_back_to_back();
    test_flush_busy();
    test_flush_complete();
    test_reset_mid_busy();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL queue_drained got %0d entries exp 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
